// File: rtl/riscv_bp_pkg.sv
// ---------------------------------------------------------------------------
// riscv_bp_pkg
// Shared constants for the dynamic branch predictor.
//   - BP_SNT / BP_WNT / BP_WT / BP_ST : 2-bit counter encodings
//       (strongly not-taken ... strongly taken).
//   - Default address, index and tag widths.
//   - Bit position where the table index starts in a PC.
//     Instructions are word aligned, so pc[1:0] carries no information.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_bp_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  localparam int BP_XLEN       = 32;
  localparam int BP_INDEX_BITS = 4;
  localparam int BP_TAG_BITS   = 8;
  localparam int BP_INDEX_LSB  = 2;

endpackage

// File: rtl/bp_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter
// Next-state function of one 2-bit saturating branch-history counter.
// Purely combinational.
// Ports:
//   cur      in  2  current counter value
//   taken    in  1  resolved branch outcome
//   force_st in  1  unconditional jump; forces strongly-taken
//   nxt      out 2  counter value to write back
// ---------------------------------------------------------------------------
module bp_sat_counter
  import riscv_bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  input  logic       force_st,
  output logic [1:0] nxt
);

  // Move one step toward the outcome.
  // The two end states hold, which gives the saturating behaviour.
  always_comb begin
    nxt = cur;
    if (force_st) begin
      nxt = BP_ST;
    end else begin
      case (cur)
        BP_SNT:  nxt = taken ? BP_WNT : BP_SNT;
        BP_WNT:  nxt = taken ? BP_WT  : BP_SNT;
        BP_WT:   nxt = taken ? BP_ST  : BP_WNT;
        default: nxt = taken ? BP_ST  : BP_WT;
      endcase
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
// Dynamic branch predictor and redirect/flush controller for a 5-stage RISC-V
// pipeline.
//   - Fetch: a 2-bit-counter BHT plus a tagged BTB, indexed by the fetch PC,
//     produce a predicted next PC.
//   - Execute: the resolved outcome is compared with the prediction that
//     travelled down the pipe. On a mispredict the controller redirects fetch
//     and flushes IF/ID and ID/EX.
// Optional feature (macro BRANCH_PRED_STATS_EN): adds 32-bit counters of
// trained branches and trained mispredicts.
// Ports:
//   clk, reset (synchronous, active-high)
//   if_pc -> pred_taken, pred_pc                          fetch prediction
//   ex_valid, ex_branch, ex_jump, ex_taken, ex_pc,
//   ex_target, ex_pred_taken, ex_pred_pc, stall           execute resolution
//   redirect, redirect_pc, flush_if_id, flush_id_ex       pipeline control
//   stat_branches, stat_mispredicts                       (only with the macro)
// ---------------------------------------------------------------------------
module branch_predict_ctrl
  import riscv_bp_pkg::*;
#(
  parameter int XLEN       = BP_XLEN,
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int TAG_BITS   = BP_TAG_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_pc,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_pc,
  input  logic            stall,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int IDX_HI  = BP_INDEX_LSB + INDEX_BITS - 1;
  localparam int TAG_LO  = BP_INDEX_LSB + INDEX_BITS;
  localparam int TAG_HI  = TAG_LO + TAG_BITS - 1;

  logic [1:0]          bht        [ENTRIES];
  logic [ENTRIES-1:0]  btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [XLEN-1:0]     btb_target [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  mispredict;
  logic                  train;
  logic [1:0]            bht_nxt;

  assign if_idx = if_pc[IDX_HI:BP_INDEX_LSB];
  assign if_tag = if_pc[TAG_HI:TAG_LO];
  assign ex_idx = ex_pc[IDX_HI:BP_INDEX_LSB];
  assign ex_tag = ex_pc[TAG_HI:TAG_LO];

  // Fetch prediction reads only the registered tables.
  // A table write at the coming edge is not forwarded.
  always_comb begin
    pred_taken = btb_valid[if_idx] & (btb_tag[if_idx] == if_tag) & bht[if_idx][1];
    pred_pc    = pred_taken ? btb_target[if_idx] : if_pc + XLEN'(4);
  end

  // A taken branch is only correct if the fetched target also matched.
  // Redirect is held low during reset, so a stale EX stage cannot steer
  // fetch while the tables reinitialise.
  always_comb begin
    mispredict  = (ex_taken != ex_pred_taken) | (ex_taken & (ex_pred_pc != ex_target));
    redirect    = ~reset & ex_valid & ex_branch & mispredict;
    redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
    flush_if_id = redirect;
    flush_id_ex = redirect;
  end

  // Training waits while stalled.
  // EX is held during a stall, so the branch trains once, in the cycle the
  // stall drops.
  assign train = ex_valid & ex_branch & ~stall;

  bp_sat_counter u_sat (
    .cur      (bht[ex_idx]),
    .taken    (ex_taken),
    .force_st (ex_jump),
    .nxt      (bht_nxt)
  );

  // Counters and valid bits carry the reset state.
  // Everything else is don't-care until its entry becomes valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        bht[k] <= BP_WNT;
      end
      btb_valid <= '0;
    end else if (train) begin
      bht[ex_idx] <= bht_nxt;
      if (ex_taken) begin
        btb_valid[ex_idx] <= 1'b1;
      end
    end
  end

  // Only taken branches allocate a BTB entry.
  // A not-taken branch keeps whatever target was already there.
  always_ff @(posedge clk) begin
    if (!reset && train && ex_taken) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= ex_target;
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  // Counts follow training, not redirects.
  // A mispredict held through a stall therefore counts once.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (train) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl
// Self-checking bench for branch_predict_ctrl.
// Runs directed scenarios first, then randomized traffic. All outputs are
// checked against a table-level reference model.
// Stats outputs are checked when BRANCH_PRED_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid, ex_branch, ex_jump, ex_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_pc;
  logic        ex_pred_taken;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if_id, flush_id_ex;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model:
  //   one int counter (0..3) per entry,
  //   plus a valid bit, a tag and a target per entry.
  int          m_ctr [16];
  bit          m_val [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int unsigned m_br, m_mis;

  always #5 clk = ~clk;

  branch_predict_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_pc       (pred_pc),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump),
    .ex_taken      (ex_taken),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_pc    (ex_pred_pc),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex)
`ifdef BRANCH_PRED_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> 6) % 256;
  endfunction

  function automatic bit model_pred_taken(input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_val[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_pred_pc(input logic [31:0] pc);
    if (model_pred_taken(pc)) return m_tgt[idx_of(pc)];
    return pc + 32'd4;
  endfunction

  function automatic bit model_mispredict();
    return (ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_pc != ex_target));
  endfunction

  function automatic bit model_redirect();
    return !reset && ex_valid && ex_branch && model_mispredict();
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic j, input logic t,
                               input logic [31:0] pc, input logic [31:0] tgt,
                               input logic pt, input logic [31:0] ppc,
                               input logic st, input logic [31:0] fpc);
    ex_valid      = v;
    ex_branch     = b;
    ex_jump       = j;
    ex_taken      = t;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pt;
    ex_pred_pc    = ppc;
    stall         = st;
    if_pc         = fpc;
  endtask

  // Compare every output against the model at the falling edge.
  // Inputs are stable by then.
  task automatic checkCycle(input string tag);
    logic [31:0] exp_rpc;
    @(negedge clk);
    exp_rpc = ex_taken ? ex_target : ex_pc + 32'd4;
    checkOutput({tag, "/pred_taken"},  64'(pred_taken),  64'(model_pred_taken(if_pc)));
    checkOutput({tag, "/pred_pc"},     64'(pred_pc),     64'(model_pred_pc(if_pc)));
    checkOutput({tag, "/redirect"},    64'(redirect),    64'(model_redirect()));
    checkOutput({tag, "/redirect_pc"}, 64'(redirect_pc), 64'(exp_rpc));
    checkOutput({tag, "/flush_if_id"}, 64'(flush_if_id), 64'(model_redirect()));
    checkOutput({tag, "/flush_id_ex"}, 64'(flush_id_ex), 64'(model_redirect()));
`ifdef BRANCH_PRED_STATS_EN
    checkOutput({tag, "/stat_br"},  64'(stat_branches),    64'(m_br));
    checkOutput({tag, "/stat_mis"}, 64'(stat_mispredicts), 64'(m_mis));
`endif
  endtask

  // Advance one clock, then update the model with the inputs held across
  // that edge.
  task automatic advance();
    int i;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        m_ctr[k] = 1;
        m_val[k] = 0;
      end
      m_br  = 0;
      m_mis = 0;
    end else if (ex_valid && ex_branch && !stall) begin
      i = idx_of(ex_pc);
      m_br++;
      if (model_mispredict()) m_mis++;
      if (ex_jump)       m_ctr[i] = 3;
      else if (ex_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      else               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      if (ex_taken) begin
        m_val[i] = 1;
        m_tag[i] = tag_of(ex_pc);
        m_tgt[i] = ex_target;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [7:0] tags [4];
    logic [31:0] pc;
    tags[0] = 8'h04;
    tags[1] = 8'h44;
    tags[2] = 8'hff;
    tags[3] = 8'h00;
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    pc = {16'h0, 2'b00, tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'b00};
    return pc;
  endfunction

  initial begin
    logic [31:0] tgts [4];
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] br0, mis0;
`endif
    tgts[0] = 32'h80;
    tgts[1] = 32'h200;
    tgts[2] = 32'h0;
    tgts[3] = 32'hFFFF_FFF0;
    for (int k = 0; k < 16; k++) begin
      m_ctr[k] = 1;
      m_val[k] = 0;
      m_tag[k] = 0;
      m_tgt[k] = 0;
    end
    m_br  = 0;
    m_mis = 0;

    // Reset, with a mispredicting branch held in EX: redirect must stay low.
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    advance();
    applyStimulus(1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104, 0, 32'h100);
    checkCycle("rst");
    checkOutput("rst_redirect", 64'(redirect), 64'd0);
    advance();
    reset = 1'b0;

    // Test 1: cold prediction, then a taken branch mispredicts.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    checkCycle("t1a");
    checkOutput("t1_pred_taken", 64'(pred_taken), 64'd0);
    checkOutput("t1_pred_pc",    64'(pred_pc),    64'h104);
    advance();
    applyStimulus(1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104, 0, 32'h100);
    checkCycle("t1b");
    checkOutput("t1_redirect",    64'(redirect),    64'd1);
    checkOutput("t1_redirect_pc", 64'(redirect_pc), 64'h80);
    checkOutput("t1_flush_if_id", 64'(flush_if_id), 64'd1);
    checkOutput("t1_flush_id_ex", 64'(flush_id_ex), 64'd1);
    advance();

    // Test 2: WT predicts taken; a correct prediction does not redirect.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    checkCycle("t2a");
    checkOutput("t2_pred_taken", 64'(pred_taken), 64'd1);
    checkOutput("t2_pred_pc",    64'(pred_pc),    64'h80);
    advance();
    applyStimulus(1, 1, 0, 1, 32'h100, 32'h80, 1, 32'h80, 0, 32'h100);
    checkCycle("t2b");
    checkOutput("t2_redirect", 64'(redirect), 64'd0);
    advance();

    // Test 3: two not-taken resolutions walk the counter from ST down to WNT.
    applyStimulus(1, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 0, 32'h100);
    checkCycle("t3a");
    checkOutput("t3_redirect",    64'(redirect),    64'd1);
    checkOutput("t3_redirect_pc", 64'(redirect_pc), 64'h104);
    advance();
    checkCycle("t3b");
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    checkCycle("t3c");
    checkOutput("t3_pred_taken", 64'(pred_taken), 64'd0);
    advance();

    // Test 4: taken with a wrong target redirects to the resolved target.
    applyStimulus(1, 1, 0, 1, 32'h100, 32'h200, 1, 32'h80, 0, 32'h100);
    checkCycle("t4a");
    checkOutput("t4_redirect",    64'(redirect),    64'd1);
    checkOutput("t4_redirect_pc", 64'(redirect_pc), 64'h200);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    checkCycle("t4b");
    checkOutput("t4_pred_pc", 64'(pred_pc), 64'h200);
    advance();

    // Test 5: 0x1100 shares the index with 0x100 but has a different tag,
    // so it must not hit.
    applyStimulus(1, 1, 0, 1, 32'h100, 32'h200, 1, 32'h200, 0, 32'h100);
    checkCycle("t5a");
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1100);
    checkCycle("t5b");
    checkOutput("t5_pred_taken", 64'(pred_taken), 64'd0);
    checkOutput("t5_pred_pc",    64'(pred_pc),    64'h1104);
    advance();

    // Test 6: a mispredict held by a stall keeps redirecting and trains once.
`ifdef BRANCH_PRED_STATS_EN
    br0  = stat_branches;
    mis0 = stat_mispredicts;
`endif
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 1, 0, 0, 32'h100, 32'h200, 1, 32'h200, 1, 32'h100);
      checkCycle("t6stall");
      checkOutput("t6_redirect",   64'(redirect),   64'd1);
      checkOutput("t6_pred_taken", 64'(pred_taken), 64'd1);
      advance();
    end
    stall = 1'b0;
    checkCycle("t6go");
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    checkCycle("t6after");
`ifdef BRANCH_PRED_STATS_EN
    checkOutput("t6_stat_br",  64'(stat_branches - br0),     64'd1);
    checkOutput("t6_stat_mis", 64'(stat_mispredicts - mis0), 64'd1);
`endif
    advance();

    // Randomized traffic: small PC pool, occasional reset, stall and jump.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      if_pc     = rand_pc();
      ex_pc     = rand_pc();
      ex_valid  = ($urandom_range(0, 9) != 0);
      ex_branch = ($urandom_range(0, 3) != 0);
      ex_jump   = ex_branch && ($urandom_range(0, 4) == 0);
      ex_taken  = ex_jump ? 1'b1 : 1'($urandom_range(0, 1));
      ex_target = tgts[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) < 7) begin
        ex_pred_taken = model_pred_taken(ex_pc);
        ex_pred_pc    = model_pred_pc(ex_pc);
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1));
        ex_pred_pc    = tgts[$urandom_range(0, 3)];
      end
      stall = ($urandom_range(0, 4) == 0);
      checkCycle("rand");
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
